// File: rtl/int_controller_if.sv
// CPU-side interrupt handshake: one-hot vector, request and id toward the CPU,
// acknowledge and end-of-interrupt pulses back from it.
interface int_controller_if;
    logic [7:0] interrupcion;
    logic       int_req;
    logic [2:0] int_id;
    logic       cpu_ack;
    logic       cpu_eoi;

    modport master (
        output interrupcion,
        output int_req,
        output int_id,
        input  cpu_ack,
        input  cpu_eoi
    );

    modport slave (
        input  interrupcion,
        input  int_req,
        input  int_id,
        output cpu_ack,
        output cpu_eoi
    );
endinterface

// File: rtl/int_controller.sv
// Interrupt controller: edge-detects peripheral levels into pending bits, masks them,
// and presents the highest-priority line to the CPU with a req/ack/eoi handshake.
module int_controller #(
    parameter int N_IRQ = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq_in,
    input  logic                 mask_we,
    input  logic [N_IRQ-1:0]     mask_in,
    output logic [N_IRQ-1:0]     pending,
    output logic [N_IRQ-1:0]     mask,
    output logic [CNT_W-1:0]     lost_cnt,
    int_controller_if.master     cpu
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] lost_q, lost_d;
    logic [N_IRQ-1:0] intr_q;
    logic             req_q;
    logic [2:0]       id_q;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic             withdraw;
    logic             ack_fire;

    // Highest set bit wins; bit 7 has top priority.
    function automatic logic [2:0] prio_idx(input logic [N_IRQ-1:0] v);
        prio_idx = 3'd0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (v[i]) prio_idx = 3'(i);
        end
    endfunction

    always_comb begin
        rise     = irq_in & ~irq_prev_q;
        eligible = pending_q & ~mask_q;
        withdraw = (state_q == REQ) && mask_q[id_q];
        ack_fire = (state_q == REQ) && cpu.cpu_ack && !withdraw;
        clr      = ack_fire ? (N_IRQ'(1) << id_q) : '0;
        // A new edge on a line being acknowledged keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_in : mask_q;
        lost_d    = lost_q;
        if ((|(rise & pending_q & ~clr)) && (lost_q != '1)) begin
            lost_d = lost_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            lost_q     <= '0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            lost_q     <= lost_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            intr_q  <= '0;
            id_q    <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible != '0) begin
                        id_q    <= prio_idx(eligible);
                        intr_q  <= N_IRQ'(1) << prio_idx(eligible);
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (withdraw) begin
                        req_q   <= 1'b0;
                        intr_q  <= '0;
                        state_q <= IDLE;
                    end else if (ack_fire) begin
                        req_q   <= 1'b0;
                        intr_q  <= '0;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (cpu.cpu_eoi) state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    intr_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pending          = pending_q;
    assign mask             = mask_q;
    assign lost_cnt         = lost_q;
    assign cpu.interrupcion = intr_q;
    assign cpu.int_req      = req_q;
    assign cpu.int_id       = id_q;

endmodule
